bpu_bht: RTL

Parametrised branch prediction unit for the pipelined RV32I core. It replaces the single-counter predictor with a table of ENTRIES saturating counters indexed by fetch PC, with optional gshare global-history indexing. It also keeps saturating branch and mispredict statistics for the hardware-test display path. Lookup sits in IF; update is driven from the branch-resolve point in EX/MEM.

---
 rtl/bpu_bht.sv | 129 ++++++++++++
 1 files changed

// File: rtl/bpu_bht.sv
// Branch history table predictor: ENTRIES saturating counters indexed by fetch PC,
// plus saturating branch/mispredict statistics. Optional gshare indexing via BPU_GSHARE_EN.
module bpu_bht #(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int GHR_W   = 6,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      lookup_pc,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    input  logic             update_valid,
    input  logic [IDX_W-1:0] update_idx,
    input  logic             update_taken,
    input  logic             update_pred,
    input  logic             clear_stats,
    output logic             mispredict,
    output logic [15:0]      branch_count,
    output logic [15:0]      mispredict_count
);

    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((2 ** (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};

    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] v, input logic up);
        logic [CTR_W-1:0] r;
        r = v;
        if (up) begin
            if (v != CTR_MAX) r = v + CTR_W'(1);
            else              r = v;
        end else begin
            if (v != {CTR_W{1'b0}}) r = v - CTR_W'(1);
            else                    r = v;
        end
        return r;
    endfunction

    function automatic logic [15:0] stat_step(input logic [15:0] v, input logic inc, input logic clr);
        logic [15:0] r;
        r = v;
        if (clr)                          r = 16'h0000;
        else if (inc && (v != 16'hFFFF))  r = v + 16'h0001;
        else                              r = v;
        return r;
    endfunction

    logic [CTR_W-1:0] ctr_r [ENTRIES];
    logic [CTR_W-1:0] ctr_next_s;
    logic [IDX_W-1:0] raw_idx_s;
    logic             mismatch_s;
    logic             mispredict_r;
    logic [15:0]      branch_count_r;
    logic [15:0]      mispredict_count_r;
    logic [15:0]      branch_next_s;
    logic [15:0]      mispredict_next_s;
    logic             unused_pc_bits_s;

    assign raw_idx_s        = lookup_pc[IDX_W+1:2];
    assign unused_pc_bits_s = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0]};
    assign mismatch_s       = update_valid & (update_taken ^ update_pred);

`ifdef BPU_GSHARE_EN
    logic [GHR_W-1:0] ghr_r;

    // Non-speculative global history, shifted at branch resolve only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_r <= {GHR_W{1'b0}};
        end else if (update_valid) begin
            ghr_r <= {ghr_r[GHR_W-2:0], update_taken};
        end else begin
            ghr_r <= ghr_r;
        end
    end

    assign pred_idx = raw_idx_s ^ IDX_W'(ghr_r);
`else
    localparam int unused_ghr_w = GHR_W;

    assign pred_idx = raw_idx_s;
`endif

    // No bypass: a same-cycle update only becomes visible after the edge.
    assign pred_taken = ctr_r[pred_idx][CTR_W-1];

    // Next value for the counter being trained.
    always_comb begin
        ctr_next_s = ctr_step(ctr_r[update_idx], update_taken);
    end

    // Counter table, one saturating step per resolved branch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i] <= CTR_INIT;
            end
        end else if (update_valid) begin
            ctr_r[update_idx] <= ctr_next_s;
        end else begin
            ctr_r[update_idx] <= ctr_r[update_idx];
        end
    end

    // Statistics next-state; clear wins over a same-cycle increment.
    always_comb begin
        branch_next_s     = stat_step(branch_count_r, update_valid, clear_stats);
        mispredict_next_s = stat_step(mispredict_count_r, mismatch_s, clear_stats);
    end

    // Mispredict pulse and statistics registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mispredict_r       <= 1'b0;
            branch_count_r     <= 16'h0000;
            mispredict_count_r <= 16'h0000;
        end else begin
            mispredict_r       <= mismatch_s;
            branch_count_r     <= branch_next_s;
            mispredict_count_r <= mispredict_next_s;
        end
    end

    assign mispredict       = mispredict_r;
    assign branch_count     = branch_count_r;
    assign mispredict_count = mispredict_count_r;

endmodule
